mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Single-port memory arbiter between the CPU and loader masters.
//               CPU has priority; a streak limiter prevents loader starvation.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int AW     = 12,
    parameter int DW     = 16,
    parameter int RD_LAT = 2,
    parameter int STREAK = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_ack,
    output logic [DW-1:0] ldr_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [3:0] C_STREAK    = 4'(STREAK);
    localparam logic [2:0] C_WAIT_INIT = 3'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_owner;     // 1 = loader owns the current access
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [3:0]    r_streak;
    logic [2:0]    r_wait;
    logic          w_any_req;
    logic          w_grant_ldr;

    assign w_any_req   = cpu_req | ldr_req;
    assign w_grant_ldr = ldr_req & (~cpu_req | (r_streak == C_STREAK));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_ack   = 1'b0;
        ldr_ack   = 1'b0;
        busy      = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = r_we;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
                w_next    = r_we ? DONE : WAIT;
            end
            WAIT: begin
                if (r_wait == 3'd0) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                cpu_ack = ~r_owner;
                ldr_ack = r_owner;
                w_next  = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner   <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_streak  <= 4'd0;
            r_wait    <= 3'd0;
            cpu_rdata <= '0;
            ldr_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_grant_ldr;
                        r_we    <= w_grant_ldr ? ldr_we    : cpu_we;
                        r_addr  <= w_grant_ldr ? ldr_addr  : cpu_addr;
                        r_wdata <= w_grant_ldr ? ldr_wdata : cpu_wdata;
                        // Streak only grows while the loader is actually kept waiting
                        if (w_grant_ldr || !ldr_req) begin
                            r_streak <= 4'd0;
                        end else begin
                            r_streak <= r_streak + 4'd1;
                        end
                    end
                end
                ISSUE: begin
                    if (!r_we) begin
                        r_wait <= C_WAIT_INIT;
                    end
                end
                WAIT: begin
                    if (r_wait != 3'd0) begin
                        r_wait <= r_wait - 3'd1;
                    end else if (r_owner) begin
                        ldr_rdata <= mem_rdata;
                    end else begin
                        cpu_rdata <= mem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
